pwm_peripheral: RTL and testbench

Register bank and 16-channel PWM generator that sits directly downstream of the SPI peripheral. It accepts validated register writes and holds five 8-bit control registers: output enables, PWM enables and a shared duty cycle. It drives 16 output pins as constant-low, constant-high or a common PWM waveform. The duty cycle is double-buffered so that a new value only takes effect at a PWM period boundary, which keeps every period glitch-free.

---
 rtl/pwm_pkg.sv | 20 ++
 rtl/pwm_timebase.sv | 30 +++
 rtl/pwm_peripheral.sv | 79 +++++++
 tb/tb_pwm_peripheral.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and the SPI->PWM write-request type for the PWM peripheral.
package pwm_pkg;

    localparam int NUM_CH = 16;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;
    localparam int         MAX_ADDR       = 4;

    localparam logic [7:0] DUTY_FULL = 8'hFF;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] data;
    } wr_req_t;

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus 8-bit PWM counter; tick per counter step, wrap at period end.
module pwm_timebase #(
    parameter int CLK_DIV = 13
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] cnt,
    output logic       tick,
    output logic       wrap
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [PW-1:0] presc;

    assign tick = (presc == PW'(CLK_DIV - 1));
    assign wrap = tick && (cnt == 8'hFF);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            cnt   <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick)
                cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/pwm_peripheral.sv
// Register bank, double-buffered duty and registered 16-channel output mux
// fed by validated writes from the SPI stage.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int CLK_DIV  = 13,
    parameter int MAX_ADDR = pwm_pkg::MAX_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [6:0]  wr_addr,
    input  logic [7:0]  wr_data,
    output logic        wr_err,
    output logic [15:0] pwm_out
);

    wr_req_t           req;
    logic              wr_fire;
    logic              in_range;
    logic [15:0]       en_out;
    logic [15:0]       en_pwm;
    logic [7:0]        duty;
    logic [7:0]        duty_sh;
    logic [7:0]        cnt;
    logic              tb_tick;
    logic              tb_wrap;
    logic              pwm_raw;
    logic [NUM_CH-1:0] pwm_next;

    assign req      = '{addr: wr_addr, data: wr_data};
    assign wr_ready = ~rst;
    assign wr_fire  = wr_valid && wr_ready;
    assign in_range = (req.addr <= 7'(MAX_ADDR));

    pwm_timebase #(.CLK_DIV(CLK_DIV)) u_timebase (
        .clk  (clk),
        .rst  (rst),
        .cnt  (cnt),
        .tick (tb_tick),
        .wrap (tb_wrap)
    );

    // Full-scale duty is treated as constant high rather than 255/256.
    assign pwm_raw = (duty_sh == DUTY_FULL) | (cnt < duty_sh);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign pwm_next[i] = en_out[i] & (~en_pwm[i] | pwm_raw);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_out  <= '0;
            en_pwm  <= '0;
            duty    <= '0;
            duty_sh <= '0;
            wr_err  <= 1'b0;
            pwm_out <= '0;
        end else begin
            wr_err <= wr_fire && !in_range;
            if (wr_fire && in_range) begin
                case (req.addr)
                    ADDR_EN_OUT_LO: en_out[7:0]  <= req.data;
                    ADDR_EN_OUT_HI: en_out[15:8] <= req.data;
                    ADDR_EN_PWM_LO: en_pwm[7:0]  <= req.data;
                    ADDR_EN_PWM_HI: en_pwm[15:8] <= req.data;
                    ADDR_DUTY:      duty         <= req.data;
                    default: ;
                endcase
            end
            // Samples the pre-edge duty, so a write on the wrap edge lands a period later.
            if (tb_tick && tb_wrap)
                duty_sh <= duty;
            pwm_out <= pwm_next;
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Scoreboard bench for pwm_peripheral: static enables, waveform timing, shadowing, errors, reset.
module tb_pwm_peripheral;
    import pwm_pkg::*;

    localparam int CLK_DIV = 13;
    localparam int PER     = 256 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [6:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_err;
    logic [15:0] pwm_out;

    int checks = 0;
    int failures = 0;
    int k = 0;
    int exp_q[$];

    pwm_peripheral #(.CLK_DIV(CLK_DIV), .MAX_ADDR(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_err   (wr_err),
        .pwm_out  (pwm_out)
    );

    always #5 clk = ~clk;

    // Non-reset edges since the last reset edge; defines the PWM phase.
    always @(posedge clk) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int e;
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if (wr_ready !== 1'b0) begin
            failures++; $display("FAIL reset_ready got=%b want=0", wr_ready);
        end
        checks++;
        if (wr_err !== 1'b0) begin
            failures++; $display("FAIL reset_err got=%b want=0", wr_err);
        end
        exp_q.push_back(0);
        e = exp_q.pop_front();
        checks++;
        if (pwm_out !== 16'(e)) begin
            failures++; $display("FAIL reset_pwm got=%h want=%h", pwm_out, 16'(e));
        end
        rst = 1'b0;
        #1;
        checks++;
        if (wr_ready !== 1'b1) begin
            failures++; $display("FAIL ready_after_reset got=%b want=1", wr_ready);
        end
    endtask

    task automatic test_static();
        int e;
        wr(ADDR_EN_OUT_LO, 8'hFF);
        wr(ADDR_EN_OUT_HI, 8'h0F);
        exp_q.push_back(16'h0FFF);
        step();
        e = exp_q.pop_front();
        checks++;
        if (pwm_out !== 16'(e)) begin
            failures++; $display("FAIL static_on got=%h want=%h", pwm_out, 16'(e));
        end
        exp_q.push_back(16'h0FFF);
        repeat (20) step();
        e = exp_q.pop_front();
        checks++;
        if (pwm_out !== 16'(e)) begin
            failures++; $display("FAIL static_hold got=%h want=%h", pwm_out, 16'(e));
        end
        do_reset();
        exp_q.push_back(0);
        e = exp_q.pop_front();
        checks++;
        if (pwm_out !== 16'(e)) begin
            failures++; $display("FAIL static_rst got=%h want=%h", pwm_out, 16'(e));
        end
        exp_q.push_back(0);
        repeat (3) step();
        e = exp_q.pop_front();
        checks++;
        if (pwm_out !== 16'(e)) begin
            failures++; $display("FAIL static_regs_cleared got=%h want=%h", pwm_out, 16'(e));
        end
    endtask

    task automatic test_errors();
        int e;
        do_reset();
        wr(ADDR_EN_OUT_LO, 8'hFF);
        wr(ADDR_EN_OUT_HI, 8'hFF);
        step();
        checks++;
        if (pwm_out !== 16'hFFFF) begin
            failures++; $display("FAIL err_setup got=%h want=ffff", pwm_out);
        end
        wr(7'h05, 8'hAA);
        checks++;
        if (wr_err !== 1'b1) begin
            failures++; $display("FAIL err_05_pulse got=%b want=1", wr_err);
        end
        wr(ADDR_EN_OUT_LO, 8'h0F);
        checks++;
        if (wr_err !== 1'b0) begin
            failures++; $display("FAIL err_05_one_cycle got=%b want=0", wr_err);
        end
        checks++;
        if (pwm_out !== 16'hFFFF) begin
            failures++; $display("FAIL err_05_nochange got=%h want=ffff", pwm_out);
        end
        exp_q.push_back(16'hFF0F);
        step();
        e = exp_q.pop_front();
        checks++;
        if (pwm_out !== 16'(e)) begin
            failures++; $display("FAIL err_next_write got=%h want=%h", pwm_out, 16'(e));
        end
        wr(7'h7F, 8'hAA);
        checks++;
        if (wr_err !== 1'b1) begin
            failures++; $display("FAIL err_7f_pulse got=%b want=1", wr_err);
        end
        step();
        checks++;
        if (wr_err !== 1'b0 || pwm_out !== 16'hFF0F) begin
            failures++; $display("FAIL err_7f_nochange err=%b pwm=%h want err=0 pwm=ff0f", wr_err, pwm_out);
        end
    endtask

    task automatic test_back_to_back();
        int e;
        wr(ADDR_EN_OUT_LO, 8'h33);
        wr(ADDR_EN_OUT_LO, 8'h55);
        exp_q.push_back(16'hFF55);
        step();
        e = exp_q.pop_front();
        checks++;
        if (pwm_out !== 16'(e)) begin
            failures++; $display("FAIL b2b_last_wins got=%h want=%h", pwm_out, 16'(e));
        end
        wr(ADDR_EN_OUT_HI, 8'h12);
        wr(ADDR_EN_OUT_LO, 8'h34);
        exp_q.push_back(16'h1234);
        step();
        e = exp_q.pop_front();
        checks++;
        if (pwm_out !== 16'(e)) begin
            failures++; $display("FAIL b2b_two_regs got=%h want=%h", pwm_out, 16'(e));
        end
    endtask

    task automatic test_reset_mid_write();
        wr(ADDR_EN_OUT_HI, 8'hFF);
        rst      = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = ADDR_EN_OUT_LO;
        wr_data  = 8'hFF;
        #1;
        checks++;
        if (wr_ready !== 1'b0) begin
            failures++; $display("FAIL rstmid_ready got=%b want=0", wr_ready);
        end
        step();
        wr_valid = 1'b0;
        rst      = 1'b0;
        checks++;
        if (pwm_out !== 16'h0000 || wr_err !== 1'b0) begin
            failures++; $display("FAIL rstmid_clear pwm=%h err=%b want 0000/0", pwm_out, wr_err);
        end
        repeat (3) step();
        checks++;
        if (pwm_out !== 16'h0000) begin
            failures++; $display("FAIL rstmid_write_dropped got=%h want=0000", pwm_out);
        end
    endtask

    task automatic test_pwm_wave();
        int hi[3];
        int pat_err = 0;
        int side_err = 0;
        int e;
        logic want;
        do_reset();
        wr(ADDR_EN_OUT_LO, 8'hFF);
        wr(ADDR_EN_OUT_HI, 8'hFF);
        wr(ADDR_EN_PWM_LO, 8'h01);
        wr(ADDR_DUTY, 8'h80);
        exp_q.push_back(0);
        exp_q.push_back(128 * CLK_DIV);
        exp_q.push_back(128 * CLK_DIV);
        hi = '{0, 0, 0};
        for (int g = 0; g < 4 * PER && k < 3 * PER; g++) begin
            step();
            if (k >= 10 && pwm_out[15:1] !== 15'h7FFF) side_err++;
            if (k >= 10 && k <= PER) hi[0] += int'(pwm_out[0]);
            if (k > PER) begin
                hi[(k - 1) / PER] += int'(pwm_out[0]);
                want = (((k - 1) % PER) / CLK_DIV) < 128;
                if (pwm_out[0] !== want) pat_err++;
            end
        end
        checks++;
        if (k < 3 * PER) begin
            failures++; $display("FAIL pwm_timeout k=%0d want=%0d", k, 3 * PER);
        end
        for (int w = 0; w < 3; w++) begin
            e = exp_q.pop_front();
            checks++;
            if (hi[w] !== e) begin
                failures++; $display("FAIL pwm_high_p%0d got=%0d want=%0d", w, hi[w], e);
            end
        end
        checks++;
        if (pat_err !== 0) begin
            failures++; $display("FAIL pwm_shape got=%0d bad cycles want=0", pat_err);
        end
        checks++;
        if (side_err !== 0) begin
            failures++; $display("FAIL pwm_static_bits got=%0d bad cycles want=0", side_err);
        end
    endtask

    // Drives duty writes at chosen phase edges and counts bit0 highs per period window.
    task automatic run_windows(input int nwin, input int wk0, input logic [7:0] wd0,
                               input int wk1, input logic [7:0] wd1, output int hi[4]);
        hi = '{0, 0, 0, 0};
        for (int g = 0; g < (nwin + 2) * PER && k < (nwin + 1) * PER; g++) begin
            wr_valid = (k == wk0 - 1) || (k == wk1 - 1);
            wr_addr  = ADDR_DUTY;
            wr_data  = (k == wk0 - 1) ? wd0 : wd1;
            step();
            wr_valid = 1'b0;
            if (k > PER) hi[(k - PER - 1) / PER] += int'(pwm_out[0]);
        end
        checks++;
        if (k < (nwin + 1) * PER) begin
            failures++; $display("FAIL window_timeout k=%0d want=%0d", k, (nwin + 1) * PER);
        end
    endtask

    task automatic test_extremes();
        int hi[4];
        int e;
        do_reset();
        wr(ADDR_EN_OUT_LO, 8'h01);
        wr(ADDR_EN_PWM_LO, 8'h01);
        wr(ADDR_DUTY, 8'h00);
        exp_q.push_back(0);
        exp_q.push_back(PER);
        run_windows(2, 5000, DUTY_FULL, -10, 8'h00, hi);
        for (int w = 0; w < 2; w++) begin
            e = exp_q.pop_front();
            checks++;
            if (hi[w] !== e) begin
                failures++; $display("FAIL extreme_p%0d got=%0d want=%0d", w, hi[w], e);
            end
        end
    endtask

    task automatic test_shadow();
        int hi[4];
        int e;
        do_reset();
        wr(ADDR_EN_OUT_LO, 8'h01);
        wr(ADDR_EN_PWM_LO, 8'h01);
        wr(ADDR_DUTY, 8'hC0);
        exp_q.push_back(8'hC0 * CLK_DIV);
        exp_q.push_back(8'h40 * CLK_DIV);
        exp_q.push_back(8'h40 * CLK_DIV);
        exp_q.push_back(8'h20 * CLK_DIV);
        // 0x40 lands mid-period; 0x20 lands exactly on a wrap edge.
        run_windows(4, PER + 672, 8'h40, 3 * PER, 8'h20, hi);
        for (int w = 0; w < 4; w++) begin
            e = exp_q.pop_front();
            checks++;
            if (hi[w] !== e) begin
                failures++; $display("FAIL shadow_p%0d got=%0d want=%0d", w, hi[w], e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_errors();
        test_back_to_back();
        test_reset_mid_write();
        test_pwm_wave();
        test_extremes();
        test_shadow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
